sss_detector: RTL

SSS_DETECTOR -- requirements
Module: sss_detector

---
 rtl/sss_pkg.sv | 23 ++
 rtl/sss_detector_if.sv | 21 ++
 rtl/sss_score.sv | 47 ++++
 rtl/sss_detector.sv | 139 +++++++++++++
 4 files changed

// File: rtl/sss_pkg.sv
// Shared constants and types for the SSS detector: base m-sequence, lengths,
// FSM encoding and a cyclic-rotate helper for the 31-chip sequence.
package sss_pkg;

  localparam int M_LEN   = 31;
  localparam int SSS_LEN = 62;

  // bit i holds x(i), x(i+5) = x(i+2) ^ x(i), seeded x(0..4) = 0,0,0,0,1
  localparam logic [M_LEN-1:0] X_SEQ = 31'b1010111011000111110011010010000;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_REPORT  = 2'd2
  } state_t;

  // result bit i = v[(i + s) % 31], valid for s in 0..31
  function automatic logic [M_LEN-1:0] rot31(input logic [M_LEN-1:0] v,
                                             input logic [4:0] s);
    return M_LEN'({v, v} >> s);
  endfunction

endpackage

// File: rtl/sss_detector_if.sv
// Bit-stream input and result bundle of the SSS detector.
interface sss_detector_if;
  logic       bit_in;
  logic       bit_valid;
  logic       busy;
  logic       done;
  logic       detected;
  logic [4:0] shift_idx;
  logic [1:0] n_id_2;
  logic [5:0] best_score;

  modport master (
    output bit_in, bit_valid,
    input  busy, done, detected, shift_idx, n_id_2, best_score
  );

  modport slave (
    input  bit_in, bit_valid,
    output busy, done, detected, shift_idx, n_id_2, best_score
  );
endinterface

// File: rtl/sss_score.sv
// Combinational candidate generation for hypothesis (n,k) and XNOR-popcount
// agreement score against the received 62-bit frame.
module sss_score
  import sss_pkg::*;
(
  input  logic [SSS_LEN-1:0] rx,
  input  logic [1:0]         n,
  input  logic [4:0]         k,
  output logic [5:0]         score
);

  logic [4:0]         k1;
  logic [4:0]         n3;
  logic [M_LEN-1:0]   xk;
  logic [M_LEN-1:0]   xk1;
  logic [M_LEN-1:0]   xn;
  logic [M_LEN-1:0]   xn3;
  logic [SSS_LEN-1:0] cand;
  logic [SSS_LEN-1:0] agree;

  always_comb begin
    k1  = (k == 5'(M_LEN - 1)) ? 5'd0 : k + 5'd1;
    n3  = {3'b000, n} + 5'd3;
    xk  = rot31(X_SEQ, k);
    xk1 = rot31(X_SEQ, k1);
    xn  = rot31(X_SEQ, n3 - 5'd3);
    xn3 = rot31(X_SEQ, n3);
  end

  // even chips pair shifts (k,n), odd chips pair (k+1,n+3)
  always_comb begin
    cand = '0;
    for (int i = 0; i < M_LEN; i++) begin
      cand[2*i]   = xk[i]  ^ xn[i];
      cand[2*i+1] = xk1[i] ^ xn3[i];
    end
  end

  always_comb begin
    agree = ~(rx ^ cand);
    score = '0;
    for (int i = 0; i < SSS_LEN; i++) begin
      score = score + {5'd0, agree[i]};
    end
  end

endmodule

// File: rtl/sss_detector.sv
// SSS detector: collects 62 hard bits, scores every (N_ID_2, shift) hypothesis
// one per cycle and reports the best one with a one-cycle done pulse.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_COLLECT | accept bit_valid bits into rx[count], count 0..61
//   ST_SEARCH  | score hypothesis (n_cur,k_cur), track strictly-better best
//   ST_REPORT  | done=1 for one cycle, inputs dropped, then back to collect
module sss_detector
  import sss_pkg::*;
#(
  parameter int THRESH  = 56,
  parameter int NUM_NID = 3
) (
  input  logic          clk,
  input  logic          reset,
  sss_detector_if.slave sss
);

  localparam logic [5:0] LAST_CNT = 6'(SSS_LEN - 1);
  localparam logic [4:0] LAST_K   = 5'(M_LEN - 1);
  localparam logic [1:0] LAST_N   = 2'(NUM_NID - 1);
  localparam logic [5:0] THRESH_S = 6'(THRESH);

  state_t             state;
  logic [5:0]         count;
  logic [SSS_LEN-1:0] rx;
  logic [1:0]         n_cur;
  logic [4:0]         k_cur;
  logic [5:0]         best_score_r;
  logic [1:0]         best_n;
  logic [4:0]         best_k;
  logic               busy_r;
  logic               done_r;
  logic               det_r;
  logic [4:0]         shift_r;
  logic [1:0]         nid_r;
  logic [5:0]         score_r;

  logic [5:0]         score;
  logic               take;
  logic [5:0]         fin_score;
  logic [1:0]         fin_n;
  logic [4:0]         fin_k;

  sss_score u_score (
    .rx    (rx),
    .n     (n_cur),
    .k     (k_cur),
    .score (score)
  );

  // the first hypothesis is always captured so a frame of zero scores still
  // reports (0,0); later ones only on a strictly higher score
  always_comb begin
    take      = ((n_cur == 2'd0) && (k_cur == 5'd0)) || (score > best_score_r);
    fin_score = take ? score : best_score_r;
    fin_n     = take ? n_cur : best_n;
    fin_k     = take ? k_cur : best_k;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_COLLECT;
      count        <= '0;
      rx           <= '0;
      n_cur        <= '0;
      k_cur        <= '0;
      best_score_r <= '0;
      best_n       <= '0;
      best_k       <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      det_r        <= 1'b0;
      shift_r      <= '0;
      nid_r        <= '0;
      score_r      <= '0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (sss.bit_valid) begin
            rx[count] <= sss.bit_in;
            if (count == LAST_CNT) begin
              state        <= ST_SEARCH;
              count        <= '0;
              busy_r       <= 1'b1;
              n_cur        <= '0;
              k_cur        <= '0;
              best_score_r <= '0;
              best_n       <= '0;
              best_k       <= '0;
            end else begin
              count <= count + 6'd1;
            end
          end
        end

        ST_SEARCH: begin
          if (take) begin
            best_score_r <= score;
            best_n       <= n_cur;
            best_k       <= k_cur;
          end
          if (k_cur == LAST_K) begin
            k_cur <= '0;
            if (n_cur == LAST_N) begin
              state   <= ST_REPORT;
              done_r  <= 1'b1;
              det_r   <= (fin_score >= THRESH_S);
              shift_r <= fin_k;
              nid_r   <= fin_n;
              score_r <= fin_score;
            end else begin
              n_cur <= n_cur + 2'd1;
            end
          end else begin
            k_cur <= k_cur + 5'd1;
          end
        end

        ST_REPORT: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= ST_COLLECT;
        end

        default: state <= ST_COLLECT;
      endcase
    end
  end

  assign sss.busy       = busy_r;
  assign sss.done       = done_r;
  assign sss.detected   = det_r;
  assign sss.shift_idx  = shift_r;
  assign sss.n_id_2     = nid_r;
  assign sss.best_score = score_r;

endmodule
